// File: rtl/fft_input_packer.sv
// fft_input_packer: front-end framer for the FFT pipeline.
// Collects serial I/Q samples into LANES-wide beats. A frame is FRAME_BEATS beats.
// A frame cut short by din_last is zero-padded out to full length.
//
// Handshake: an input sample transfers on a rising clk edge where din_valid && din_ready.
// din_ready does not depend on din_valid. The output side has no back-pressure.
// dout_valid is a one-cycle pulse that the downstream stage must take.
module fft_input_packer #(
    parameter int LANES       = 16,
    parameter int DW          = 9,
    parameter int FRAME_BEATS = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          din_valid,
    input  logic [DW-1:0] din_i,
    input  logic [DW-1:0] din_q,
    input  logic          din_last,
    output logic          din_ready,
    output logic          dout_valid,
    output logic [DW-1:0] dout_i [0:LANES-1],
    output logic [DW-1:0] dout_q [0:LANES-1],
    output logic          dout_sof,
    output logic          dout_eof,
    output logic          dbg_state_o
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int BW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;

    typedef enum logic {
        FILL = 1'b0,
        PAD  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            alive_q;
    logic [LW-1:0]   lane_cnt_q, lane_cnt_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [DW-1:0]   stage_i_q [0:LANES-1];
    logic [DW-1:0]   stage_q_q [0:LANES-1];
    logic [DW-1:0]   stage_i_d [0:LANES-1];
    logic [DW-1:0]   stage_q_d [0:LANES-1];
    logic [DW-1:0]   dout_i_q  [0:LANES-1];
    logic [DW-1:0]   dout_q_q  [0:LANES-1];
    logic [DW-1:0]   dout_i_d  [0:LANES-1];
    logic [DW-1:0]   dout_q_d  [0:LANES-1];
    logic            dout_valid_q, dout_valid_d;
    logic            dout_sof_q, dout_sof_d;
    logic            dout_eof_q, dout_eof_d;
    logic            accept;
    logic            emit;
    logic            lane_full;
    logic            beat_last;

    // alive_q keeps din_ready low through reset and for the first edge after release.
    assign din_ready   = alive_q && (state_q == FILL);
    assign accept      = din_valid && din_ready;
    assign lane_full   = (lane_cnt_q == LW'(LANES - 1));
    assign beat_last   = (beat_cnt_q == BW'(FRAME_BEATS - 1));
    assign dout_valid  = dout_valid_q;
    assign dout_sof    = dout_sof_q;
    assign dout_eof    = dout_eof_q;
    assign dout_i      = dout_i_q;
    assign dout_q      = dout_q_q;
    assign dbg_state_o = state_q;

    // State, counters and the ready qualifier.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= FILL;
            alive_q    <= 1'b0;
            lane_cnt_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            alive_q    <= 1'b1;
            lane_cnt_q <= lane_cnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Staging lanes and registered output beat with its flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage_i_q    <= '{default: '0};
            stage_q_q    <= '{default: '0};
            dout_i_q     <= '{default: '0};
            dout_q_q     <= '{default: '0};
            dout_valid_q <= 1'b0;
            dout_sof_q   <= 1'b0;
            dout_eof_q   <= 1'b0;
        end else begin
            stage_i_q    <= stage_i_d;
            stage_q_q    <= stage_q_d;
            dout_i_q     <= dout_i_d;
            dout_q_q     <= dout_q_d;
            dout_valid_q <= dout_valid_d;
            dout_sof_q   <= dout_sof_d;
            dout_eof_q   <= dout_eof_d;
        end
    end

    // Next-state: fill lanes, assemble beats, and run the zero-padding tail of a short frame.
    always_comb begin
        state_d      = state_q;
        lane_cnt_d   = lane_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        stage_i_d    = stage_i_q;
        stage_q_d    = stage_q_q;
        dout_i_d     = dout_i_q;
        dout_q_d     = dout_q_q;
        dout_valid_d = 1'b0;
        dout_sof_d   = 1'b0;
        dout_eof_d   = 1'b0;
        emit         = 1'b0;

        case (state_q)
            FILL: begin
                if (accept) begin
                    stage_i_d[lane_cnt_q] = din_i;
                    stage_q_d[lane_cnt_q] = din_q;
                    if (lane_full || din_last) begin
                        // Lanes below the current one come from staging. The current lane
                        // takes the live sample. Lanes above are zero (only reachable on din_last).
                        emit       = 1'b1;
                        lane_cnt_d = '0;
                        for (int k = 0; k < LANES; k++) begin
                            if (k < int'(lane_cnt_q)) begin
                                dout_i_d[k] = stage_i_q[k];
                                dout_q_d[k] = stage_q_q[k];
                            end else if (k == int'(lane_cnt_q)) begin
                                dout_i_d[k] = din_i;
                                dout_q_d[k] = din_q;
                            end else begin
                                dout_i_d[k] = '0;
                                dout_q_d[k] = '0;
                            end
                        end
                        if (din_last && !beat_last) begin
                            state_d = PAD;
                        end
                    end else begin
                        lane_cnt_d = lane_cnt_q + LW'(1);
                    end
                end
            end
            PAD: begin
                // beat_cnt back at 0 means the eof beat is on the output this cycle.
                // Stay in PAD for that cycle so din_ready rises only after the eof pulse.
                if (beat_cnt_q == '0) begin
                    state_d = FILL;
                end else begin
                    emit     = 1'b1;
                    dout_i_d = '{default: '0};
                    dout_q_d = '{default: '0};
                end
            end
            default: state_d = FILL;
        endcase

        if (emit) begin
            dout_valid_d = 1'b1;
            dout_sof_d   = (beat_cnt_q == '0);
            dout_eof_d   = beat_last;
            beat_cnt_d   = beat_last ? '0 : beat_cnt_q + BW'(1);
        end
    end

endmodule
